vga_timing_gen: RTL and testbench

- Raster timing generator for the 640x480@60 VGA output path, running from the 50 MHz board clock.
- Produces the pixel clock-enable, registered h_sync/v_sync, the display-enable window, the active pixel coordinates, and line/frame start strobes.
- Sits directly upstream of the colour/pattern stage, which uses x/y/disp_en to choose its 4-bit R/G/B levels.
- Replaces ad-hoc divided clocks and sync-derived clock edges with a single clock domain.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pix_ce_gen.sv | 37 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the 640x480@60 VGA path; used by the timing
// generator and by the colour stage that consumes x/y/disp_en.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic SYNC_POL_LOW  = 1'b0;
  localparam logic SYNC_POL_HIGH = 1'b1;

  // Half-open interval test [lo, hi) used for all region decodes.
  function automatic logic in_span(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_pix_ce_gen.sv
// Pixel clock-enable divider: one-clk pix_ce pulse every CLK_DIV clocks,
// keeping the whole raster path in the single clk domain.
module vga_pix_ce_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_range_chk
      $error("vga_pix_ce_gen: CLK_DIV must be in 1..16");
    end
  endgenerate

  logic [DW-1:0] r_div_cnt;
  logic          r_pix_ce;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_pix_ce  <= 1'b0;
    end else begin
      r_pix_ce  <= (r_div_cnt == DIV_LAST);
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
    end
  end

  assign pix_ce = r_pix_ce;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel counters, registered sync/display-enable
// and coordinate outputs, plus line/frame start strobes aligned to pix_ce.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = SYNC_POL_LOW,
  parameter logic VS_POL   = SYNC_POL_LOW
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_ce,
  output logic               h_sync,
  output logic               v_sync,
  output logic               disp_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  generate
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_total_chk
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic               w_pix_ce;
  logic               w_active;
  logic               w_hs_region;
  logic               w_vs_region;
  logic               w_line_start;

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic               r_h_sync;
  logic               r_v_sync;
  logic               r_disp_en;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  vga_pix_ce_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_ce_gen (
    .clk   (clk),
    .rst   (rst),
    .pix_ce(w_pix_ce)
  );

  assign w_active    = in_span(int'(r_h_cnt), 0, H_ACTIVE) && in_span(int'(r_v_cnt), 0, V_ACTIVE);
  assign w_hs_region = in_span(int'(r_h_cnt), HS_BEG, HS_END);
  assign w_vs_region = in_span(int'(r_v_cnt), VS_BEG, VS_END);

  // Outputs are loaded from the pre-advance counter value, so they trail the
  // counters by one pixel and hold steady for the whole pixel period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_h_sync  <= ~HS_POL;
      r_v_sync  <= ~VS_POL;
      r_disp_en <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else if (w_pix_ce) begin
      r_disp_en <= w_active;
      r_x       <= w_active ? r_h_cnt : '0;
      r_y       <= w_active ? r_v_cnt : '0;
      r_h_sync  <= w_hs_region ? HS_POL : ~HS_POL;
      r_v_sync  <= w_vs_region ? VS_POL : ~VS_POL;
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + COORD_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + COORD_W'(1);
      end
    end
  end

  // Strobes are gated by the registered pix_ce so they live exactly in the
  // pix_ce clk in which the counters sit on the first pixel.
  assign w_line_start = w_pix_ce && (r_h_cnt == '0);

  assign pix_ce      = w_pix_ce;
  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign disp_en     = r_disp_en;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = w_line_start;
  assign frame_start = w_line_start && (r_v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus two reduced rasters
// (CLK_DIV=2 low-polarity, CLK_DIV=1 high-polarity) against a time-based model.
module tb_vga_timing_gen;

  typedef struct packed {
    int   d;
    int   ha;
    int   hfp;
    int   hsw;
    int   hbp;
    int   va;
    int   vfp;
    int   vsw;
    int   vbp;
    logic hp;
    logic vp;
  } geom_t;

  localparam geom_t GA = '{d:2, ha:640, hfp:16, hsw:96, hbp:48,
                           va:480, vfp:10, vsw:2, vbp:33, hp:1'b0, vp:1'b0};
  localparam geom_t GB = '{d:2, ha:16, hfp:2, hsw:4, hbp:3,
                           va:8, vfp:2, vsw:2, vbp:3, hp:1'b0, vp:1'b0};
  localparam geom_t GC = '{d:1, ha:16, hfp:2, hsw:4, hbp:3,
                           va:8, vfp:2, vsw:2, vbp:3, hp:1'b1, vp:1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  always #5 clk = ~clk;

  logic       a_ce, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_ce, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_ce, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .pix_ce(a_ce), .h_sync(a_hs), .v_sync(a_vs),
    .disp_en(a_de), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(GB.d), .H_ACTIVE(GB.ha), .H_FP(GB.hfp), .H_SYNC(GB.hsw), .H_BP(GB.hbp),
    .V_ACTIVE(GB.va), .V_FP(GB.vfp), .V_SYNC(GB.vsw), .V_BP(GB.vbp),
    .HS_POL(GB.hp), .VS_POL(GB.vp)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .pix_ce(b_ce), .h_sync(b_hs), .v_sync(b_vs),
    .disp_en(b_de), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(GC.d), .H_ACTIVE(GC.ha), .H_FP(GC.hfp), .H_SYNC(GC.hsw), .H_BP(GC.hbp),
    .V_ACTIVE(GC.va), .V_FP(GC.vfp), .V_SYNC(GC.vsw), .V_BP(GC.vbp),
    .HS_POL(GC.hp), .VS_POL(GC.vp)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .pix_ce(c_ce), .h_sync(c_hs), .v_sync(c_vs),
    .disp_en(c_de), .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs k clk edges after the last reset edge, computed from
  // elapsed time: pix_ce clks are k = j*d (j>=1); the pixel shown is the
  // number of completed pix_ce edges minus one.
  function automatic logic [25:0] model(input geom_t g, input int k);
    int ht, vt, p, h, v;
    logic ce, hs, vs, de, ls, fs;
    logic [9:0] xx, yy;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    ce = (k >= g.d) && (k % g.d == 0);
    hs = ~g.hp; vs = ~g.vp; de = 1'b0; xx = '0; yy = '0; ls = 1'b0; fs = 1'b0;
    if (ce) begin
      p  = k / g.d - 1;
      ls = (p % ht == 0);
      fs = (p % (ht * vt) == 0);
    end
    if (k >= g.d + 1) begin
      p  = (k - 1) / g.d - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      de = (h < g.ha) && (v < g.va);
      if (de) begin
        xx = 10'(h);
        yy = 10'(v);
      end
      if (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hsw) hs = g.hp;
      if (v >= g.va + g.vfp && v < g.va + g.vfp + g.vsw) vs = g.vp;
    end
    return {ce, hs, vs, de, xx, yy, ls, fs};
  endfunction

  // ---------------- scoreboard ----------------
  logic [25:0] exp_qa[$];
  logic [25:0] exp_qb[$];
  logic [25:0] exp_qc[$];
  int k_a = 0;
  int k_b = 0;
  int k_c = 0;

  always @(posedge clk) begin
    k_a = rst_a ? 0 : k_a + 1;
    k_b = rst_b ? 0 : k_b + 1;
    k_c = rst_c ? 0 : k_c + 1;
    exp_qa.push_back(model(GA, k_a));
    exp_qb.push_back(model(GB, k_b));
    exp_qc.push_back(model(GC, k_c));
  end

  always @(negedge clk) begin
    if (exp_qa.size() > 0)
      check_eq("sb_a", 32'({a_ce, a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs}), 32'(exp_qa.pop_front()));
    if (exp_qb.size() > 0)
      check_eq("sb_b", 32'({b_ce, b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs}), 32'(exp_qb.pop_front()));
    if (exp_qc.size() > 0)
      check_eq("sb_c", 32'({c_ce, c_hs, c_vs, c_de, c_x, c_y, c_ls, c_fs}), 32'(exp_qc.pop_front()));
  end

  // ---------------- driver tasks ----------------
  localparam int SEL_A_CE = 0;
  localparam int SEL_A_LS = 1;
  localparam int SEL_B_FS = 2;
  localparam int SEL_C_FS = 3;

  function automatic logic get_sig(input int sel);
    case (sel)
      SEL_A_CE: return a_ce;
      SEL_A_LS: return a_ls;
      SEL_B_FS: return b_fs;
      default:  return c_fs;
    endcase
  endfunction

  // Clks until the selected signal is seen high; -1 when the budget expires.
  task automatic wait_sig(input int sel, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (get_sig(sel)) return;
    end
    n = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, de_n, hs_n, vs_n, ce_lo, max_x, max_y, bad_coord;

    repeat (3) @(negedge clk);
    check_eq("a_reset_state", 32'({a_ce, a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs}),
             32'({1'b0, ~GA.hp, ~GA.vp, 1'b0, 20'd0, 2'b00}));
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Default raster: first pix_ce latency, then two full lines.
    wait_sig(SEL_A_CE, 20, n);
    check_eq("a_first_ce_clks", n, 2);
    check_eq("a_first_frame_start", 32'(a_fs), 1);
    for (int l = 0; l < 2; l++) begin
      gap = 0; de_n = 0; hs_n = 0;
      do begin
        @(negedge clk);
        gap++;
        if (a_ce && a_de) de_n++;
        if (a_ce && a_hs == GA.hp) hs_n++;
      end while (!a_ls && gap < 5000);
      check_eq("a_line_clks", gap, 1600);
      check_eq("a_line_de_pixels", de_n, 640);
      check_eq("a_line_hsync_pixels", hs_n, 96);
    end

    // Reduced raster B: one whole frame.
    wait_sig(SEL_B_FS, 2000, n);
    check_eq("b_fs_found", 32'(n > 0), 1);
    gap = 0; de_n = 0; vs_n = 0; max_x = 0; max_y = 0; bad_coord = 0;
    do begin
      @(negedge clk);
      gap++;
      if (b_de) de_n++;
      if (b_vs == GB.vp) vs_n++;
      if (b_de && int'(b_x) > max_x) max_x = int'(b_x);
      if (b_de && int'(b_y) > max_y) max_y = int'(b_y);
      if (!b_de && (b_x != 0 || b_y != 0)) bad_coord++;
    end while (!b_fs && gap < 5000);
    check_eq("b_frame_clks", gap, 25 * 15 * 2);
    check_eq("b_frame_de_clks", de_n, 16 * 8 * 2);
    check_eq("b_frame_vsync_clks", vs_n, 2 * 25 * 2);
    check_eq("b_last_x", max_x, 15);
    check_eq("b_last_y", max_y, 7);
    check_eq("b_blank_coord_zero", bad_coord, 0);

    // Mid-frame single-clk reset on B.
    n = 0;
    while (!(b_de && b_y == 10'd5 && b_x == 10'd10) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("b_mid_point_found", 32'(n < 2000), 1);
    rst_b = 1'b1;
    @(negedge clk);
    check_eq("b_mid_reset_state", 32'({b_ce, b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs}),
             32'({1'b0, ~GB.hp, ~GB.vp, 1'b0, 20'd0, 2'b00}));
    rst_b = 1'b0;
    wait_sig(SEL_B_FS, 20, n);
    check_eq("b_restart_fs_clks", n, 2);

    // Raster C: CLK_DIV=1 with active-high syncs.
    wait_sig(SEL_C_FS, 1000, n);
    check_eq("c_fs_found", 32'(n > 0), 1);
    gap = 0; hs_n = 0; vs_n = 0; ce_lo = 0;
    do begin
      @(negedge clk);
      gap++;
      if (!c_ce) ce_lo++;
      if (c_hs) hs_n++;
      if (c_vs) vs_n++;
    end while (!c_fs && gap < 2000);
    check_eq("c_frame_clks", gap, 25 * 15);
    check_eq("c_ce_low_clks", ce_lo, 0);
    check_eq("c_hsync_high_clks", hs_n, 4 * 15);
    check_eq("c_vsync_high_clks", vs_n, 2 * 25);

    // Random idle run keeps the per-clk scoreboard exercising all three.
    repeat ($urandom_range(50, 200)) @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
